// File: rtl/count_seq_ctrl.sv
// Run-sequencing controller: runs a WIDTH-bit counter from a latched load value to a latched terminal value.
// Optional COUNT_SEQ_PERIODS_EN adds a saturating count of terminal events on port periods.
module count_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  periodic,
    input  logic                  up_dn,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      term_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  tc
`ifdef COUNT_SEQ_PERIODS_EN
    ,
    output logic [7:0]            periods
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] presc;
    logic [WIDTH-1:0]      load_sh;
    logic [WIDTH-1:0]      term_sh;
    logic [PRESCALE_W-1:0] prescale_sh;
    logic                  periodic_sh;
    logic                  up_sh;
    logic                  tick;

    // Modulo-2^WIDTH step; wrap in either direction is intentional.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
        return up ? v + 1'b1 : v - 1'b1;
    endfunction

    assign tick = (presc == prescale_sh);
    assign busy = (state == ARM) || (state == RUN) || (state == HOLD);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            presc       <= '0;
            load_sh     <= '0;
            term_sh     <= '0;
            prescale_sh <= '0;
            periodic_sh <= 1'b0;
            up_sh       <= 1'b0;
            tc          <= 1'b0;
`ifdef COUNT_SEQ_PERIODS_EN
            periods     <= 8'd0;
`endif
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        load_sh     <= load_val;
                        term_sh     <= term_val;
                        prescale_sh <= prescale;
                        periodic_sh <= periodic;
                        up_sh       <= up_dn;
                        state       <= ARM;
`ifdef COUNT_SEQ_PERIODS_EN
                        periods     <= 8'd0;
`endif
                    end
                end
                ARM: begin
                    if (stop) begin
                        state <= IDLE;
                    end else begin
                        count <= load_sh;
                        presc <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // stop beats pause beats tick; the pausing edge takes no tick.
                    if (stop) begin
                        state <= IDLE;
                    end else if (pause) begin
                        state <= HOLD;
                    end else if (tick) begin
                        presc <= '0;
                        if (count == term_sh) begin
                            tc <= 1'b1;
`ifdef COUNT_SEQ_PERIODS_EN
                            if (periods != 8'hFF) periods <= periods + 8'd1;
`endif
                            if (periodic_sh) count <= load_sh;
                            else             state <= DONE;
                        end else begin
                            count <= step(count, up_sh);
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                HOLD: begin
                    if (stop)        state <= IDLE;
                    else if (!pause) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl; periods checks compile only with COUNT_SEQ_PERIODS_EN.
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, pause, periodic, up_dn;
    logic [3:0] load_val, term_val, prescale;
    logic [3:0] count;
    logic       busy, done, tc;
`ifdef COUNT_SEQ_PERIODS_EN
    logic [7:0] periods;
`endif

    int checks = 0;
    int errors = 0;

    count_seq_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .up_dn(up_dn), .load_val(load_val),
        .term_val(term_val), .prescale(prescale), .count(count),
        .busy(busy), .done(done), .tc(tc)
`ifdef COUNT_SEQ_PERIODS_EN
        , .periods(periods)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] l, input logic [3:0] t, input logic [3:0] p,
                       input logic per, input logic up);
        load_val = l; term_val = t; prescale = p; periodic = per; up_dn = up;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int exp_dn [9] = '{1, 0, 15, 14, 1, 0, 15, 14, 1};
    int exp_tc [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_per[10] = '{5, 6, 7, 5, 6, 7, 5, 6, 7, 5};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tc", tc, 0);
        tick();
        chk("idle_stays", busy, 0);

        // one-shot up 3..7
        cfg(4'd3, 4'd7, 4'd0, 1'b0, 1'b1);
        launch();
        chk("arm_busy", busy, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("up_count", count, 3 + i);
            chk("up_tc", tc, 0);
            chk("up_done", done, 0);
            tick();
        end
        chk("up_term_tc", tc, 1);
        chk("up_term_done", done, 1);
        chk("up_term_busy", busy, 0);
        chk("up_term_count", count, 7);
        tick();
        chk("up_tc_once", tc, 0);
        chk("up_hold_count", count, 7);

        // periodic down with wrap, restarted from DONE
        cfg(4'd1, 4'd14, 4'd0, 1'b1, 1'b0);
        launch();
        chk("dn_arm_done", done, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("dn_count", count, exp_dn[i]);
            chk("dn_tc", tc, exp_tc[i]);
            chk("dn_done", done, 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("dn_stop_busy", busy, 0);
        chk("dn_stop_done", done, 0);
        chk("dn_stop_count", count, 0);
        chk("dn_stop_tc", tc, 0);

        // prescale 2, one-shot 0..2
        cfg(4'd0, 4'd2, 4'd2, 1'b0, 1'b1);
        launch();
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("ps_count", count, i / 3);
            chk("ps_tc", tc, 0);
            chk("ps_busy", busy, 1);
            tick();
        end
        chk("ps_done", done, 1);
        chk("ps_tc_end", tc, 1);
        chk("ps_count_end", count, 2);
        tick();
        chk("ps_tc_once", tc, 0);

        // pause with prescale 1: freeze at count 4, prescaler mid-period
        cfg(4'd0, 4'd9, 4'd1, 1'b0, 1'b1);
        launch();
        tick();
        repeat (9) tick();
        chk("pz_pre_count", count, 4);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pz_count", count, 4);
            chk("pz_busy", busy, 1);
        end
        pause = 1'b0;
        tick();
        chk("pz_resume_count", count, 4);
        tick();
        chk("pz_next_count", count, 5);
        repeat (2) tick();
        chk("pz_six", count, 6);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_tc", tc, 0);
        tick();
        chk("stop_count", count, 6);
        chk("stop_tc2", tc, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        tick();
        chk("ss_busy2", busy, 0);
        chk("ss_count", count, 6);

        // term_val changed mid-run is ignored
        cfg(4'd5, 4'd7, 4'd0, 1'b1, 1'b1);
        launch();
        term_val = 4'd2;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("shadow_count", count, exp_per[i]);
            chk("shadow_tc", tc, (i == 3 || i == 6 || i == 9) ? 1 : 0);
            if (i < 9) tick();
        end
`ifdef COUNT_SEQ_PERIODS_EN
        chk("periods_3", periods, 3);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cfg(4'd0, 4'd2, 4'd0, 1'b0, 1'b1);
        launch();
`ifdef COUNT_SEQ_PERIODS_EN
        chk("periods_clr", periods, 0);
`endif
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("newterm_count", count, i);
            tick();
        end
        chk("newterm_done", done, 1);
        chk("newterm_tc", tc, 1);

        // load == term: 1-tick run
        cfg(4'd4, 4'd4, 4'd0, 1'b0, 1'b0);
        launch();
        tick();
        chk("one_count", count, 4);
        chk("one_done0", done, 0);
        tick();
        chk("one_done", done, 1);
        chk("one_tc", tc, 1);

`ifdef COUNT_SEQ_PERIODS_EN
        cfg(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        launch();
        repeat (300) tick();
        chk("periods_sat", periods, 255);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif

        // async reset mid-run at count 5
        cfg(4'd0, 4'd9, 4'd0, 1'b0, 1'b1);
        launch();
        tick();
        repeat (5) tick();
        chk("ar_pre_count", count, 5);
        #2 rst = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_tc", tc, 0);
        #1 rst = 1'b0;
        repeat (2) tick();
        chk("ar_idle_busy", busy, 0);
        chk("ar_idle_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Run-sequencing controller for the team's free-running up-counter datapath.
- Owns a WIDTH-bit counter and runs it from a programmed load value to a terminal value.
- Supports up or down counting, a cycle prescaler, and one-shot or auto-reload (periodic) operation.
- Provides start/stop/pause control and busy/done/terminal-count status to a host FSM.

Parameters:
- WIDTH, 4: counter width in bits.
- PRESCALE_W, 4: prescaler width; count advances once every prescale+1 RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE or DONE.
- stop  input  1  abort run; returns to IDLE.
- pause  input  1  level; freezes count and prescaler while high during a run.
- periodic  input  1  1 = auto-reload at terminal; 0 = one-shot.
- up_dn  input  1  1 = count up; 0 = count down.
- load_val  input  WIDTH  run start value.
- term_val  input  WIDTH  terminal value.
- prescale  input  PRESCALE_W  tick divider minus one.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high in ARM, RUN, HOLD.
- done  output  1  high in DONE.
- tc  output  1  one-cycle registered terminal-count pulse.

Behaviour:
- Reset (asynchronous, no clock needed): state=IDLE, count=0, prescaler=0, shadow registers=0, busy=0, done=0, tc=0.
- FSM states: IDLE, ARM, RUN, HOLD, DONE. busy and done decode directly from the state register (Moore).
- Priority order: rst > stop > pause > tick.
- IDLE:
  - start=1 -> ARM.
  - Latch load_val, term_val, prescale, periodic and up_dn into shadow registers.
  - Config inputs are ignored at all other times.
- ARM (exactly 1 cycle): count<=load shadow, prescaler<=0 -> RUN.
  - First count value is visible 2 edges after start is sampled.
- RUN:
  - tick = (prescaler == prescale shadow). On tick, prescaler<=0; otherwise prescaler+1.
  - On tick with count != term: count<=count+1 (up) or count-1 (down), modulo 2^WIDTH. Wrap-around is legal: 15->0 up, 0->15 down.
  - On tick with count == term: tc<=1 next cycle.
    - periodic=1: count<=load shadow, stay RUN.
    - periodic=0: -> DONE, count held at term.
  - Run length in ticks = ((T-L) mod 2^WIDTH)+1 for up, ((L-T) mod 2^WIDTH)+1 for down. load==term gives a 1-tick run.
- HOLD: entered from RUN when pause=1 at an edge. No tick is taken on that edge. count and prescaler are frozen. pause=0 -> RUN, resuming the prescaler where it stopped.
- DONE:
  - done=1; count holds term.
  - start=1 -> ARM with a fresh shadow latch.
  - stop=1 -> IDLE.
- stop in ARM, RUN or HOLD -> IDLE next edge. count retains its value; no tc is generated.
- stop and start in the same cycle: stop wins and the state stays or goes IDLE.
- tc: high for exactly one cycle after each terminal event, never otherwise. It coincides with count showing load (periodic) or done rising (one-shot).
- rst mid-run: immediate return to reset values. The next run requires a fresh start.

Optional Feature:
- Macro: COUNT_SEQ_PERIODS_EN.
- Defined:
  - Adds output port periods [7:0], cleared by reset and on every IDLE/DONE->ARM transition.
  - Increments on each terminal event and saturates at 255. No wrap.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Drive rst high asynchronously mid-RUN at count=5 -> count=0, busy=0, done=0, tc=0 before the next clk edge; after release, state stays IDLE.
- One-shot up: load=3, term=7, prescale=0, start pulse -> count 3,4,5,6,7 on consecutive cycles; tc pulses once as done rises; count holds 7; busy=0.
- Periodic down with wrap: load=1, term=14, up_dn=0, prescale=0 -> count 1,0,15,14,1,0,15,14...; tc every 4 cycles; done stays 0.
- Prescale=2, load=0, term=2, up, one-shot -> each value held 3 cycles; DONE reached after 9 RUN cycles; single tc.
- Pause and stop:
  - pause high 5 cycles at count=4 -> count and prescaler frozen, busy=1; resumes at 5 after release.
  - stop at count=6 -> IDLE, count stays 6, no tc.
  - start+stop in the same cycle -> remains IDLE.
- Change term_val from 7 to 2 during RUN -> run still ends at 7. The next start uses 2. With COUNT_SEQ_PERIODS_EN, periods=3 after 3 periodic terminals.
